ok_btpipe_in_buffer: RTL

- Block-throttled pipe-in receive buffer. Sits directly downstream of the host-interface endpoint bus (primary or secondary host side).
- Accepts host pipe-write words in fixed-size blocks and stores them in a FIFO. Advertises `ep_ready` only when a whole block fits.
- Presents the buffered words to user logic as a valid/ready stream. Flags protocol and overflow errors.

---
 rtl/ok_btpipe_pkg.sv | 26 ++
 rtl/ok_sync_fifo.sv | 78 +++++++
 rtl/ok_btpipe_in_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ok_btpipe_pkg.sv
// Shared types and width helpers for the block-throttled pipe-in buffer.
// Stats counter widths apply only when OK_BTPIPE_STATS_EN is defined.
package ok_btpipe_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BLOCK = 1'b1
   } state_t;

   localparam int BLOCKS_DONE_W   = 32;
   localparam int WORDS_DROPPED_W = 16;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Level must represent DEPTH itself, hence one extra bit.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int blk_cnt_w(input int block_words);
      return $clog2(block_words + 1);
   endfunction

endpackage

// File: rtl/ok_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output stage.
// level counts words in memory plus the one held in the output register.
module ok_sync_fifo
   import ok_btpipe_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 1024,
   localparam int AW     = addr_w(DEPTH),
   localparam int LW     = level_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_acc,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready,
   output logic [LW-1:0]     level,
   output logic [LW-1:0]     level_nxt
);

   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     mem_cnt;
   logic              xfer;
   logic              load;

   assign xfer   = rd_valid & rd_ready;
   // A transfer in the same cycle frees a slot, so a write at full is still taken.
   assign wr_acc = wr & ((level != FULL_LVL) | xfer);
   assign load   = (mem_cnt != '0) & (!rd_valid | xfer);

   always_comb begin
      level_nxt = level;
      if (wr_acc & !xfer)
         level_nxt = level + 1'b1;
      else if (!wr_acc & xfer)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         level    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (load) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         case ({wr_acc, load})
            2'b10:   mem_cnt <= mem_cnt + 1'b1;
            2'b01:   mem_cnt <= mem_cnt - 1'b1;
            default: mem_cnt <= mem_cnt;
         endcase
         level <= level_nxt;
         if (load)
            rd_valid <= 1'b1;
         else if (xfer)
            rd_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ok_btpipe_in_buffer.sv
// Block-throttled pipe-in receive buffer: host block FSM, ep_ready and error flags.
// Define OK_BTPIPE_STATS_EN to add saturating blocks_done / words_dropped counters.
module ok_btpipe_in_buffer
   import ok_btpipe_pkg::*;
#(
   parameter  int DATA_W      = 32,
   parameter  int DEPTH       = 1024,
   parameter  int BLOCK_WORDS = 256,
   localparam int LW          = level_w(DEPTH)
) (
   input  logic              okClk,
   input  logic              okRst_n,
   input  logic              ep_write,
   input  logic              ep_blockstrobe,
   input  logic [DATA_W-1:0] ep_dataout,
   output logic              ep_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [LW-1:0]     level,
   output logic              overflow,
   output logic              block_err,
   input  logic              clear_err
`ifdef OK_BTPIPE_STATS_EN
   ,
   output logic [BLOCKS_DONE_W-1:0]   blocks_done,
   output logic [WORDS_DROPPED_W-1:0] words_dropped
`endif
);

   localparam int              CW        = blk_cnt_w(BLOCK_WORDS);
   localparam logic [CW-1:0]   LAST_CNT  = CW'(BLOCK_WORDS);
   localparam logic [LW-1:0]   DEPTH_LVL = LW'(DEPTH);
   localparam logic [LW-1:0]   BLOCK_LVL = LW'(BLOCK_WORDS);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   blk_cnt;
   logic [CW-1:0]   blk_cnt_nxt;
   logic            wr_acc;
   logic [LW-1:0]   level_nxt;
   logic            proto_evt;
   logic            drop_evt;
   logic            block_done;
   logic            ep_ready_nxt;

   ok_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (okClk),
      .rst_n     (okRst_n),
      .wr        (ep_write),
      .wr_data   (ep_dataout),
      .wr_acc    (wr_acc),
      .rd_valid  (m_valid),
      .rd_data   (m_data),
      .rd_ready  (m_ready),
      .level     (level),
      .level_nxt (level_nxt)
   );

   assign drop_evt = ep_write & !wr_acc;

   always_comb begin
      state_nxt   = state;
      blk_cnt_nxt = blk_cnt;
      proto_evt   = 1'b0;
      block_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ep_blockstrobe & ep_ready) begin
               state_nxt   = ST_BLOCK;
               blk_cnt_nxt = CW'(ep_write);
            end else begin
               // Rejected strobe or stray write outside a block; the word itself still goes to the FIFO.
               proto_evt = ep_blockstrobe | ep_write;
            end
         end
         ST_BLOCK: begin
            if (ep_blockstrobe) begin
               proto_evt   = 1'b1;
               blk_cnt_nxt = CW'(ep_write);
            end else if (ep_write) begin
               blk_cnt_nxt = blk_cnt + 1'b1;
               if (blk_cnt_nxt == LAST_CNT) begin
                  state_nxt   = ST_IDLE;
                  block_done  = 1'b1;
                  blk_cnt_nxt = '0;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign ep_ready_nxt = (state_nxt == ST_IDLE) && ((DEPTH_LVL - level_nxt) >= BLOCK_LVL);

   always_ff @(posedge okClk or negedge okRst_n) begin
      if (!okRst_n) begin
         state     <= ST_IDLE;
         blk_cnt   <= '0;
         ep_ready  <= 1'b0;
         overflow  <= 1'b0;
         block_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         blk_cnt   <= blk_cnt_nxt;
         ep_ready  <= ep_ready_nxt;
         // Set beats clear when both happen in the same cycle.
         overflow  <= drop_evt  | (overflow  & !clear_err);
         block_err <= proto_evt | (block_err & !clear_err);
      end
   end

`ifdef OK_BTPIPE_STATS_EN
   always_ff @(posedge okClk or negedge okRst_n) begin
      if (!okRst_n) begin
         blocks_done   <= '0;
         words_dropped <= '0;
      end else begin
         if (clear_err)
            blocks_done <= BLOCKS_DONE_W'(block_done);
         else if (block_done && !(&blocks_done))
            blocks_done <= blocks_done + 1'b1;
         if (clear_err)
            words_dropped <= WORDS_DROPPED_W'(drop_evt);
         else if (drop_evt && !(&words_dropped))
            words_dropped <= words_dropped + 1'b1;
      end
   end
`endif

endmodule
